// File: rtl/sf2_reset_sequencer.sv
// Reset sequencer: qualifies POR, external, user and software reset sources against config-done
// and PLL lock, then releases NUM_DOMAINS reset domains one by one in index order.
module sf2_reset_sequencer #(
    parameter int unsigned NUM_DOMAINS         = 3,
    parameter int unsigned NUM_LOCKS           = 1,
    parameter logic [3:0]  LOCK_USED           = 4'b0001,
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned STRETCH_CYCLES      = 200,
    parameter int unsigned STEP_CYCLES         = 4,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 0,
    parameter logic [7:0]  USER_RST_MASK       = 8'hFF,
    parameter int unsigned EXT_OUT_MODE        = 2
) (
    input  logic                   RCOSC_25_50MHZ,
    input  logic                   POWER_ON_RESET_N,
    input  logic                   CONFIG_DONE,
    input  logic                   EXT_RESET_IN_N,
    input  logic                   USER_FAB_RESET_IN_N,
    input  logic [NUM_LOCKS-1:0]   LOCK,
    input  logic                   SW_RESET_REQ,
    input  logic                   CLR_INIT_DONE,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
    output logic                   EXT_RESET_OUT,
    output logic                   INIT_DONE,
    output logic                   LOCK_TIMEOUT,
    output logic [2:0]             SEQ_STATE
);
    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_STRETCH = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_ABORT   = 3'd5;

    localparam int unsigned CNT_MAX_A = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES
                                                                       : STEP_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A
                                                                          : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned REL_W     = $clog2(NUM_DOMAINS + 1);
    localparam int unsigned SW        = NUM_LOCKS + 3;
    localparam bit          TO_EN     = (LOCK_TIMEOUT_CYCLES != 0);
    localparam int unsigned TO_LAST   = TO_EN ? LOCK_TIMEOUT_CYCLES - 1 : 0;
    localparam logic        EXT_RST   = (EXT_OUT_MODE != 0);

    // All synchroniser reset values (config low, locks low, resets asserted) happen to be 0.
    logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
    logic [SW-1:0]                  sync_out;
    logic                           cfg_s, ext_s, usr_s, locks_ok, qual, abort;
    logic [NUM_LOCKS-1:0]           lock_s;

    always_ff @(posedge RCOSC_25_50MHZ or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       {CONFIG_DONE, EXT_RESET_IN_N, USER_FAB_RESET_IN_N, LOCK}};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign cfg_s    = sync_out[SW-1];
    assign ext_s    = sync_out[SW-2];
    assign usr_s    = sync_out[SW-3];
    assign lock_s   = sync_out[NUM_LOCKS-1:0];
    assign locks_ok = &(lock_s | ~LOCK_USED[NUM_LOCKS-1:0]);
    assign qual     = cfg_s && locks_ok && ext_s;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [REL_W-1:0]       rel_q, rel_d;
    logic                   init_q, init_d, to_q, to_d, ext_q, ext_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;

    // Lock loss is ignored while a timeout bypass is in force.
    assign abort   = !ext_s || (!locks_ok && !to_q) || SW_RESET_REQ;
    assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        init_d  = init_q;
        to_d    = to_q;
        case (state_q)
            ST_RESET, ST_ABORT: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (qual) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end else if (TO_EN && cfg_s && ext_s && (cnt_q >= CNT_W'(TO_LAST))) begin
                    to_d    = 1'b1;
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = locks_ok ? '0 : cnt_inc;
                end
            end
            ST_STRETCH, ST_RELEASE, ST_RUN: begin
                if (abort) begin
                    state_d = ST_ABORT;
                    cnt_d   = '0;
                    rel_d   = '0;
                    init_d  = 1'b0;
                end else if (state_q == ST_STRETCH) begin
                    if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                        cnt_d   = '0;
                        rel_d   = REL_W'(1);
                        state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                        init_d  = (NUM_DOMAINS == 1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                        cnt_d = '0;
                        rel_d = rel_q + 1'b1;
                        if (rel_q == REL_W'(NUM_DOMAINS - 1)) begin
                            state_d = ST_RUN;
                            init_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
                rel_d   = '0;
            end
        endcase
        if (CLR_INIT_DONE) begin
            init_d = 1'b0;
            to_d   = 1'b0;
        end
    end

    always_comb begin
        dom_d = '0;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            dom_d[i] = (32'(rel_d) > i) && !(USER_RST_MASK[i] && !usr_s);
        end
        if (EXT_OUT_MODE == 0) begin
            ext_d = 1'b0;
        end else if (EXT_OUT_MODE == 1) begin
            ext_d = ~dom_d[0];
        end else begin
            ext_d = (state_d != ST_RUN);
        end
    end

    always_ff @(posedge RCOSC_25_50MHZ or negedge POWER_ON_RESET_N) begin
        if (!POWER_ON_RESET_N) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rel_q   <= '0;
            init_q  <= 1'b0;
            to_q    <= 1'b0;
            dom_q   <= '0;
            ext_q   <= EXT_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            init_q  <= init_d;
            to_q    <= to_d;
            dom_q   <= dom_d;
            ext_q   <= ext_d;
        end
    end

    assign DOMAIN_RESET_N = dom_q;
    assign EXT_RESET_OUT  = ext_q;
    assign INIT_DONE      = init_q;
    assign LOCK_TIMEOUT   = to_q;
    assign SEQ_STATE      = state_q;

endmodule

// File: tb/tb_sf2_reset_sequencer.sv
// Bench for sf2_reset_sequencer: vector table, hand-written corner sequences, then random
// traffic compared against a release-schedule reference model.
module tb_sf2_reset_sequencer;
    localparam int ND   = 3;
    localparam int S    = 16;
    localparam int STEP = 4;
    localparam int TO   = 100;
    localparam logic [2:0] MASK = 3'b110;

    logic       clk = 1'b0;
    logic       por_n = 1'b0, cfg = 1'b0, ext_n = 1'b0, usr_n = 1'b0, sw = 1'b0, clr = 1'b0;
    logic [0:0] lock = 1'b0;
    logic [2:0] dom;
    logic       eo_out, init, lto;
    logic [2:0] st;

    int errors = 0;
    int checks = 0;

    sf2_reset_sequencer #(
        .NUM_DOMAINS(ND), .NUM_LOCKS(1), .LOCK_USED(4'b0001), .SYNC_STAGES(2),
        .STRETCH_CYCLES(S), .STEP_CYCLES(STEP), .LOCK_TIMEOUT_CYCLES(TO),
        .USER_RST_MASK({5'b0, MASK}), .EXT_OUT_MODE(2)
    ) dut (
        .RCOSC_25_50MHZ(clk), .POWER_ON_RESET_N(por_n), .CONFIG_DONE(cfg),
        .EXT_RESET_IN_N(ext_n), .USER_FAB_RESET_IN_N(usr_n), .LOCK(lock),
        .SW_RESET_REQ(sw), .CLR_INIT_DONE(clr), .DOMAIN_RESET_N(dom),
        .EXT_RESET_OUT(eo_out), .INIT_DONE(init), .LOCK_TIMEOUT(lto), .SEQ_STATE(st)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] want, input int limit);
        int k = 0;
        while (st !== want && k < limit) begin
            step(1);
            k++;
        end
        check("wait_state", {29'd0, st}, {29'd0, want});
    endtask

    // Reference model: tracks when stretching began and derives releases from elapsed time.
    int         m_st, m_start, m_miss, m_n;
    bit         m_init, m_to;
    logic [2:0] m_dom;
    logic [3:0] hist[$];

    function automatic int released(input int t);
        int r = 0;
        for (int i = 0; i < ND; i++) if (t >= S + i * STEP) r++;
        return r;
    endfunction

    task automatic model_reset();
        m_st = 0; m_start = 0; m_miss = 0; m_n = 0; m_init = 0; m_to = 0; m_dom = '0;
        hist.delete();
        hist.push_back(4'b0000);
        hist.push_back(4'b0000);
    endtask

    task automatic model_step();
        logic [3:0] d;
        bit c, e, u, l;
        int rel;
        hist.push_back({cfg, ext_n, usr_n, lock[0]});
        d = hist.pop_front();
        c = d[3]; e = d[2]; u = d[1]; l = d[0];
        m_n++;
        case (m_st)
            0, 5: begin m_st = 1; m_miss = 0; end
            1: begin
                if (c && e && l) begin
                    m_st = 2; m_start = m_n;
                end else if (!l && c && e && m_miss + 1 >= TO) begin
                    m_to = 1; m_st = 2; m_start = m_n;
                end else begin
                    m_miss = l ? 0 : m_miss + 1;
                end
            end
            default: begin
                if (!e || (!l && !m_to) || sw) begin
                    m_st = 5; m_init = 0;
                end else begin
                    rel = released(m_n - m_start);
                    if (rel == ND && m_st != 4) begin
                        m_st = 4; m_init = 1;
                    end else if (rel > 0 && rel < ND) begin
                        m_st = 3;
                    end
                end
            end
        endcase
        if (clr) begin m_init = 0; m_to = 0; end
        rel = (m_st >= 2 && m_st <= 4) ? released(m_n - m_start) : 0;
        for (int i = 0; i < ND; i++) m_dom[i] = (i < rel) && !(MASK[i] && !u);
    endtask

    typedef struct {
        int         adv;
        logic       sw;
        logic       clr;
        logic [2:0] dom;
        logic       init;
        logic [2:0] st;
    } vec_t;

    vec_t vt[15];

    initial begin
        vt[0]  = '{1,  1'b0, 1'b0, 3'b000, 1'b0, 3'd1};
        vt[1]  = '{2,  1'b0, 1'b0, 3'b000, 1'b0, 3'd2};
        vt[2]  = '{15, 1'b0, 1'b0, 3'b000, 1'b0, 3'd2};
        vt[3]  = '{1,  1'b0, 1'b0, 3'b001, 1'b0, 3'd3};
        vt[4]  = '{3,  1'b0, 1'b0, 3'b001, 1'b0, 3'd3};
        vt[5]  = '{1,  1'b0, 1'b0, 3'b011, 1'b0, 3'd3};
        vt[6]  = '{3,  1'b0, 1'b0, 3'b011, 1'b0, 3'd3};
        vt[7]  = '{1,  1'b0, 1'b0, 3'b111, 1'b1, 3'd4};
        vt[8]  = '{1,  1'b1, 1'b0, 3'b000, 1'b0, 3'd5};
        vt[9]  = '{1,  1'b0, 1'b0, 3'b000, 1'b0, 3'd1};
        vt[10] = '{1,  1'b0, 1'b0, 3'b000, 1'b0, 3'd2};
        vt[11] = '{16, 1'b0, 1'b0, 3'b001, 1'b0, 3'd3};
        vt[12] = '{8,  1'b0, 1'b0, 3'b111, 1'b1, 3'd4};
        vt[13] = '{1,  1'b0, 1'b1, 3'b111, 1'b0, 3'd4};
        vt[14] = '{5,  1'b0, 1'b0, 3'b111, 1'b0, 3'd4};

        // Reset values while POR is held.
        repeat (2) @(posedge clk);
        #1;
        check("por_hold", {23'd0, dom, init, lto, st, eo_out}, {23'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1});
        cfg = 1'b1; lock = 1'b1; ext_n = 1'b1; usr_n = 1'b1;
        #2 por_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            sw = vt[i].sw; clr = vt[i].clr;
            step(1);
            sw = 1'b0; clr = 1'b0;
            if (vt[i].adv > 1) step(vt[i].adv - 1);
            check($sformatf("vec%0d", i), {23'd0, dom, init, lto, st, eo_out},
                  {23'd0, vt[i].dom, vt[i].init, 1'b0, vt[i].st, vt[i].st != 3'd4});
        end

        // External reset between the domain 0 and domain 1 releases.
        sw = 1'b1; step(1); sw = 1'b0;
        step(18);
        check("ext_pre", {29'd0, dom}, 32'b001);
        ext_n = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step(1);
            check($sformatf("ext_d1_%0d", j), {31'd0, dom[1]}, 32'd0);
        end
        check("ext_abort", {26'd0, dom, st}, {26'd0, 3'b000, 3'd5});
        ext_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step(1);
            check("ext_after", {29'd0, dom}, 32'd0);
        end
        wait_state(3'd4, 80);

        // User fabric reset hits masked domains only.
        usr_n = 1'b0;
        step(2);
        check("usr_lat", {29'd0, dom}, 32'b111);
        step(1);
        check("usr_low", {27'd0, dom, init, lto}, {27'd0, 3'b001, 1'b1, 1'b0});
        step(7);
        usr_n = 1'b1;
        check("usr_hold", {26'd0, dom, st}, {26'd0, 3'b001, 3'd4});
        step(2);
        check("usr_rec_lat", {29'd0, dom}, 32'b001);
        step(1);
        check("usr_rec", {28'd0, dom, init}, {28'd0, 3'b111, 1'b1});

        // Lock loss, timeout bypass, completion and clear.
        lock = 1'b0;
        step(2);
        check("lk_pre", {26'd0, dom, st}, {26'd0, 3'b111, 3'd4});
        step(1);
        check("lk_abort", {26'd0, dom, st}, {26'd0, 3'b000, 3'd5});
        step(1);
        check("lk_wait", {29'd0, st}, 32'd1);
        step(99);
        check("to_before", {28'd0, lto, st}, {28'd0, 1'b0, 3'd1});
        step(1);
        check("to_set", {28'd0, lto, st}, {28'd0, 1'b1, 3'd2});
        step(24);
        check("to_run", {24'd0, dom, init, lto, st}, {24'd0, 3'b111, 1'b1, 1'b1, 3'd4});
        step(5);
        check("to_noabort", {29'd0, st}, 32'd4);
        clr = 1'b1; step(1); clr = 1'b0;
        check("to_clr", {27'd0, init, lto, st}, {27'd0, 1'b0, 1'b0, 3'd4});
        step(1);
        check("to_clr_abort", {29'd0, st}, 32'd5);
        lock = 1'b1;
        wait_state(3'd4, 80);

        // Asynchronous POR in the middle of stretching.
        sw = 1'b1; step(1); sw = 1'b0;
        step(7);
        check("por_pre", {29'd0, st}, 32'd2);
        #2 por_n = 1'b0;
        #1;
        check("por_async", {23'd0, dom, init, lto, st, eo_out},
              {23'd0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1});

        // Randomized traffic against the reference model.
        step(2);
        model_reset();
        #2 por_n = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            cfg   = cfg   ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 19) == 0);
            lock  = lock  ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 119) == 0);
            ext_n = ext_n ? ($urandom_range(0, 499) != 0) : ($urandom_range(0, 7) == 0);
            usr_n = usr_n ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 14) == 0);
            sw    = ($urandom_range(0, 299) == 0);
            clr   = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand%0d", n), {23'd0, dom, init, lto, st, eo_out},
                  {23'd0, m_dom, m_init, m_to, m_st[2:0], m_st != 4});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
